// File: rtl/div_sequencer.sv
// div_sequencer: iterative radix-2 restoring divider for the RV32IM EX stage.
// Handles DIV/DIVU/REM/REMU on operand magnitudes and fixes the signs at the
// end. It holds the PC and IF/ID register through stall_o while it iterates.
// Divide-by-zero and signed overflow skip the iteration and finish one cycle
// after acceptance.

module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             kill_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             negQuo_q, negQuo_d;
   logic             negRem_q, negRem_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] result_q, result_d;

   // Operand decode for the IDLE cycle: signedness, magnitudes, special cases.
   logic             inSigned;
   logic             dividendNeg;
   logic             divisorNeg;
   logic [WIDTH-1:0] dividendMag;
   logic [WIDTH-1:0] divisorMag;
   logic             divByZero;
   logic             overflow;
   logic             accept;

   // One iteration of the restoring step, computed on the extended remainder.
   logic [WIDTH+1:0] remShift;
   logic [WIDTH:0]   dvsExt;
   logic [WIDTH:0]   remSub;
   logic             remGe;

   // Sign-corrected quotient and remainder, used in FIX.
   logic [WIDTH-1:0] quoFix;
   logic [WIDTH-1:0] remFix;
   logic             opSigned;

   // Decode the incoming operation and detect the bypass cases.
   always_comb begin
      inSigned    = ~op_i[0];
      dividendNeg = inSigned & dividend_i[WIDTH-1];
      divisorNeg  = inSigned & divisor_i[WIDTH-1];
      dividendMag = dividendNeg ? ((~dividend_i) + ONE) : dividend_i;
      divisorMag  = divisorNeg ? ((~divisor_i) + ONE) : divisor_i;
      divByZero   = (divisor_i == '0);
      overflow    = inSigned & (dividend_i == MIN_INT) & (divisor_i == ALL_ONES);
      accept      = start_i & ~kill_i;
   end

   // Shift {rem, quo} left by one and trial-subtract the divisor magnitude.
   always_comb begin
      remShift = {rem_q, quo_q[WIDTH-1]};
      dvsExt   = {1'b0, dvs_q};
      remGe    = (remShift >= {1'b0, dvsExt});
      remSub   = remShift[WIDTH:0] - dvsExt;
   end

   // Apply the recorded signs to the finished magnitudes.
   always_comb begin
      opSigned = ~op_q[0];
      quoFix   = (opSigned & negQuo_q) ? ((~quo_q) + ONE) : quo_q;
      remFix   = (opSigned & negRem_q) ? ((~rem_q[WIDTH-1:0]) + ONE) : rem_q[WIDTH-1:0];
   end

   // Next-state logic for the sequencer FSM and iteration counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d = '0;
               if (divByZero || overflow) begin
                  state_d = DONE;
               end else begin
                  state_d = DIV;
               end
            end
         end
         DIV: begin
            if (kill_i) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH-1)) begin
                  state_d = FIX;
               end
            end
         end
         FIX: begin
            state_d = kill_i ? IDLE : DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath updates: latch on accept, iterate in DIV, write result in FIX.
   always_comb begin
      op_d     = op_q;
      negQuo_d = negQuo_q;
      negRem_d = negRem_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      result_d = result_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               op_d     = op_i;
               negQuo_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
               negRem_d = dividend_i[WIDTH-1];
               rem_d    = '0;
               quo_d    = dividendMag;
               dvs_d    = divisorMag;
               if (divByZero) begin
                  result_d = op_i[1] ? dividend_i : ALL_ONES;
               end else if (overflow) begin
                  result_d = op_i[1] ? '0 : MIN_INT;
               end
            end
         end
         DIV: begin
            if (!kill_i) begin
               rem_d = remGe ? remSub : remShift[WIDTH:0];
               quo_d = {quo_q[WIDTH-2:0], remGe};
            end
         end
         FIX: begin
            if (!kill_i) begin
               result_d = op_q[1] ? remFix : quoFix;
            end
         end
         default: begin
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         negQuo_q <= 1'b0;
         negRem_q <= 1'b0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         negQuo_q <= negQuo_d;
         negRem_q <= negRem_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         result_q <= result_d;
      end
   end

   // Pipeline-facing status; stall drops in DONE so EX/MEM can capture.
   always_comb begin
      stall_o  = ((state_q == IDLE) & start_i & ~kill_i) | (state_q == DIV) | (state_q == FIX);
      busy_o   = (state_q != IDLE);
      done_o   = (state_q == DONE);
      result_o = result_q;
   end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Iterative divide sequencer for the RV32IM execute stage. It performs DIV/DIVU/REM/REMU with a radix-2 restoring algorithm. While it runs, it drives the pipeline stall that holds the PC and the IF/ID register. It sits beside the EX-stage ALU: the control path raises start_i when a divide-class instruction occupies EX, and the sequencer holds the pipeline until result_o is valid for the EX/MEM register.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported for RV32.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  a divide-class instruction is in EX; sampled only in IDLE.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i.
- dividend_i  in  WIDTH  rs1 value after forwarding; sampled with start_i.
- divisor_i  in  WIDTH  rs2 value after forwarding; sampled with start_i.
- kill_i  in  1  abort the current operation (EX flush); no result is produced.
- stall_o  out  1  hold pc_en/if_id_en/ID-EX low; combinational.
- busy_o  out  1  state is not IDLE; registered.
- done_o  out  1  result_o is valid this cycle; a one-cycle pulse.
- result_o  out  WIDTH  quotient or remainder; held until the next accepted start.

## Operation
- States: IDLE, DIV, FIX, DONE.
- Reset: state IDLE, counter 0, all internal registers 0, result_o 0, done_o 0, busy_o 0.
- IDLE, start_i=1: latch op_i and the operand magnitudes.
  - Signed ops (DIV, REM) take the absolute value.
  - Record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
- IDLE, special-case bypass to DONE (result written on that edge):
  - divisor == 0: quotient = all ones (0xFFFFFFFF); remainder = dividend.
  - Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient 0x80000000; remainder 0.
- IDLE, otherwise: go to DIV with counter 0.
- DIV, each cycle:
  - Shift {rem, quo} left by 1.
  - If the shifted rem >= divisor magnitude, subtract it and set the quotient LSB.
  - Counter increments; after count 31 (32 iterations), go to FIX.
- FIX:
  - Quotient negated when signed and sign_q=1.
  - Remainder negated when signed and sign_r=1.
  - Select the quotient (op_i[1]=0) or the remainder (op_i[1]=1) into result_o.
  - Go to DONE.
- DONE: done_o=1. Unconditionally return to IDLE. start_i is ignored in DONE, because it still reflects the same instruction.
- kill_i=1 in DIV or FIX: go to IDLE on the next edge. No done_o; result_o unchanged.
- kill_i in IDLE overrides start_i, so the operation is not accepted.
- kill_i in DONE has no effect.
- rst has priority over everything, in any state.
- Arithmetic: the remainder register is WIDTH+1 bits for the compare/subtract. Negation is two's complement truncated to WIDTH.

## Timing
- stall_o = (IDLE & start_i & ~kill_i) | DIV | FIX. It is never asserted in DONE, so the pipeline advances while done_o is high.
- Start accepted in cycle 0 (IDLE): DIV in cycles 1..32, FIX in cycle 33, DONE (done_o=1) in cycle 34. Total stall is 34 cycles.
- Special-case bypass: cycle 0 IDLE, cycle 1 DONE. Stall is 1 cycle.
- busy_o is high from cycle 1 through the DONE cycle inclusive.
- Operands and op_i may change after cycle 0 without effect.
- Back-to-back: the earliest next acceptance is the cycle after DONE.
- Reset mid-operation: the next cycle is IDLE, stall_o=0 (unless start_i is high), and result_o=0.

## Test plan
- DIV 0xFFFFFFF9 (-7) / 2, start in cycle 0 -> stall_o high cycles 0-33; done_o only in cycle 34; result_o 0xFFFFFFFD.
- REM -7 / 2 -> 0xFFFFFFFF. REMU 0xFFFFFFF9 / 2 -> 1. DIVU 100 / 7 -> 14.
- DIVU 100 / 0 -> done_o in cycle 1, result_o 0xFFFFFFFF. REM 100 / 0 -> 0x64. Stall is 1 cycle in both cases.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in cycle 1. REM of the same operands -> 0.
- kill_i pulsed in cycle 10 of a DIVU -> IDLE in cycle 11, stall_o low, done_o never asserted, result_o keeps its previous value.
- rst in cycle 20 of a DIV -> cycle 21: busy_o 0, result_o 0, done_o 0.
- Two DIVUs back-to-back, with start_i held high through DONE -> second acceptance in cycle 35, second done_o in cycle 69.
